// File: rtl/lcd_bus_driver_if.sv
// Handshake and LCD bus bundle between the text sequencer (master) and lcd_bus_driver (slave).
// Signal names keep the established upstream/LCD pin names.
interface lcd_bus_driver_if;
    logic [7:0] iDATA;
    logic       iRS;
    logic       iStart;
    logic       oDone;
    logic       oBusy;
    logic [7:0] LCD_DATA;
    logic       LCD_RS;
    logic       LCD_EN;
    logic       LCD_RW;

    modport master (
        output iDATA, iRS, iStart,
        input  oDone, oBusy, LCD_DATA, LCD_RS, LCD_EN, LCD_RW
    );

    modport slave (
        input  iDATA, iRS, iStart,
        output oDone, oBusy, LCD_DATA, LCD_RS, LCD_EN, LCD_RW
    );
endinterface

// File: rtl/lcd_bus_driver.sv
// HD44780 write-only bus driver: one 9-bit word per start/done handshake, with setup,
// enable pulse, hold and execution wait timed by a single shared down-counter.
module lcd_bus_driver #(
    parameter int T_AS        = 2,
    parameter int T_EN        = 16,
    parameter int T_H         = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000,
    parameter int CW          = 17
) (
    input  logic iCLK,
    input  logic iRST_N,
    lcd_bus_driver_if.slave bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_ENABLE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [CW-1:0] LD_AS   = CW'(T_AS - 1);
    localparam logic [CW-1:0] LD_EN   = CW'(T_EN - 1);
    localparam logic [CW-1:0] LD_H    = CW'(T_H - 1);
    localparam logic [CW-1:0] LD_EXEC = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] LD_LONG = CW'(T_EXEC_LONG - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          armed_q, armed_d;
    logic [7:0]    data_q,  data_d;
    logic          rs_q,    rs_d;
    logic          en_q,    en_d;
    logic          done_q,  done_d;
    logic          busy_q,  busy_d;

    logic cnt_zero;
    logic long_cmd;

    assign cnt_zero = (cnt_q == '0);
    // Clear (0x01) and Home (0x02/0x03) instructions need the long execution wait.
    assign long_cmd = !rs_q && (data_q[7:2] == 6'b0);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - CW'(1);
        armed_d = armed_q;
        data_d  = data_q;
        rs_d    = rs_q;
        en_d    = en_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            S_IDLE: begin
                if (!bus.iStart) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    data_d  = bus.iDATA;
                    rs_d    = bus.iRS;
                    armed_d = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = LD_AS;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_zero) begin
                    en_d    = 1'b1;
                    cnt_d   = LD_EN;
                    state_d = S_ENABLE;
                end
            end
            S_ENABLE: begin
                if (cnt_zero) begin
                    en_d    = 1'b0;
                    cnt_d   = LD_H;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_zero) begin
                    cnt_d   = long_cmd ? LD_LONG : LD_EXEC;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_zero) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                en_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Async reset also truncates an EN pulse in flight; the aborted word never reports done.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            armed_q <= 1'b1;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.LCD_DATA = data_q;
    assign bus.LCD_RS   = rs_q;
    assign bus.LCD_EN   = en_q;
    assign bus.LCD_RW   = 1'b0;
    assign bus.oDone    = done_q;
    assign bus.oBusy    = busy_q;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Bench for lcd_bus_driver: per-word cycle-accurate timing checks plus an LCD bus model
// that pops expected words from a scoreboard queue on every EN pulse.
module tb_lcd_bus_driver;

    localparam int T_AS        = 2;
    localparam int T_EN        = 16;
    localparam int T_H         = 2;
    // Shortened execution waits keep the full init/text stream within a small cycle budget.
    localparam int T_EXEC      = 300;
    localparam int T_EXEC_LONG = 1200;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } word_t;

    logic iCLK = 1'b0;
    logic iRST_N;

    always #10 iCLK = ~iCLK;

    lcd_bus_driver_if bus();

    lcd_bus_driver #(
        .T_AS(T_AS), .T_EN(T_EN), .T_H(T_H),
        .T_EXEC(T_EXEC), .T_EXEC_LONG(T_EXEC_LONG), .CW(17)
    ) dut (
        .iCLK(iCLK),
        .iRST_N(iRST_N),
        .bus(bus)
    );

    int    checks = 0;
    int    errors = 0;
    word_t exp_q[$];
    int    en_pulses   = 0;
    int    done_pulses = 0;
    bit    in_abort    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge iCLK) if (bus.oDone) done_pulses++;

    // LCD bus model: captures the word on each EN pulse and measures its width.
    word_t mon_got, mon_exp;
    int    mon_w;
    initial begin
        forever begin
            @(posedge bus.LCD_EN);
            mon_w   = 0;
            mon_got = {bus.LCD_RS, bus.LCD_DATA};
            do begin
                @(negedge iCLK);
                if (bus.LCD_EN) begin
                    mon_w++;
                    mon_got = {bus.LCD_RS, bus.LCD_DATA};
                end
            end while (bus.LCD_EN);
            en_pulses++;
            if (!in_abort) begin
                check("sb_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_exp = exp_q.pop_front();
                    check("sb_word", mon_got, mon_exp);
                    check("en_width", mon_w, T_EN);
                end
            end
        end
    end

    // One transaction; cycle k values are observed on the falling edge before rising edge k.
    task automatic send(input logic [7:0] d, input logic rs, input bit glitch, input bit hold);
        int n, rise_k, fall_k, done_k, dcount;
        bit bus_ok, rw_ok, busy_ok;
        n = 1 + T_AS + T_EN + T_H + ((!rs && d <= 8'h03) ? T_EXEC_LONG : T_EXEC);
        @(negedge iCLK);
        bus.iDATA  = d;
        bus.iRS    = rs;
        bus.iStart = 1'b1;
        exp_q.push_back({rs, d});
        @(posedge iCLK);
        rise_k = -1; fall_k = -1; done_k = -1; dcount = 0;
        bus_ok = 1'b1; rw_ok = 1'b1; busy_ok = 1'b1;
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge iCLK);
            if (glitch && k == 5) begin
                bus.iDATA = 8'hFF;
                bus.iRS   = 1'b0;
            end
            if (bus.LCD_DATA !== d || bus.LCD_RS !== rs) bus_ok = 1'b0;
            if (bus.LCD_RW !== 1'b0) rw_ok = 1'b0;
            if (bus.oBusy !== (k <= n)) busy_ok = 1'b0;
            if (bus.LCD_EN === 1'b1 && rise_k < 0) rise_k = k;
            if (bus.LCD_EN === 1'b0 && rise_k >= 0 && fall_k < 0) fall_k = k;
            if (bus.oDone === 1'b1) begin
                dcount++;
                done_k = k;
                if (!hold) bus.iStart = 1'b0;
            end
        end
        check("bus_stable", bus_ok, 1);
        check("lcd_rw_low", rw_ok, 1);
        check("busy_window", busy_ok, 1);
        check("en_rise_cycle", rise_k, 1 + T_AS);
        check("en_fall_cycle", fall_k, 1 + T_AS + T_EN);
        check("done_cycle", done_k, n);
        check("done_count", dcount, 1);
    endtask

    word_t stream[38];
    string txt;
    int    p0, d0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        iRST_N     = 1'b0;
        bus.iDATA  = 8'h00;
        bus.iRS    = 1'b0;
        bus.iStart = 1'b0;
        #25;
        check("rst_lcd_data", bus.LCD_DATA, 8'h00);
        check("rst_lcd_rs", bus.LCD_RS, 0);
        check("rst_lcd_en", bus.LCD_EN, 0);
        check("rst_lcd_rw", bus.LCD_RW, 0);
        check("rst_done", bus.oDone, 0);
        check("rst_busy", bus.oBusy, 0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (2) @(negedge iCLK);

        // Data write with input glitch, then iStart stuck high.
        send(8'h41, 1'b1, 1'b1, 1'b1);
        p0 = en_pulses;
        d0 = done_pulses;
        repeat (5000) @(negedge iCLK);
        check("stuck_en_pulses", en_pulses, p0);
        check("stuck_done_pulses", done_pulses, d0);
        check("stuck_busy", bus.oBusy, 0);
        check("idle_keeps_data", bus.LCD_DATA, 8'h41);
        check("idle_keeps_rs", bus.LCD_RS, 1);
        @(negedge iCLK);
        bus.iStart = 1'b0;
        send(8'h01, 1'b0, 1'b0, 1'b0);
        send(8'h38, 1'b0, 1'b0, 1'b0);
        send(8'h04, 1'b0, 1'b0, 1'b0);
        send(8'h01, 1'b1, 1'b0, 1'b0);

        // Reset during the EN pulse.
        @(negedge iCLK);
        bus.iDATA  = 8'h5A;
        bus.iRS    = 1'b1;
        bus.iStart = 1'b1;
        @(posedge iCLK);
        repeat (10) @(negedge iCLK);
        check("abort_en_before", bus.LCD_EN, 1);
        d0 = done_pulses;
        in_abort = 1'b1;
        #2 iRST_N = 1'b0;
        #1;
        check("abort_en", bus.LCD_EN, 0);
        check("abort_data", bus.LCD_DATA, 8'h00);
        check("abort_rs", bus.LCD_RS, 0);
        check("abort_busy", bus.oBusy, 0);
        bus.iStart = 1'b0;
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (T_EXEC_LONG + 40) @(negedge iCLK);
        check("abort_no_done", done_pulses, d0);
        in_abort = 1'b0;
        send(8'h41, 1'b1, 1'b0, 1'b0);

        // Sequencer-style init/text stream, issued back-to-back.
        stream[0] = {1'b0, 8'h38};
        stream[1] = {1'b0, 8'h0C};
        stream[2] = {1'b0, 8'h01};
        stream[3] = {1'b0, 8'h06};
        stream[4] = {1'b0, 8'h80};
        txt = "A:0123456789ABCDEFGHIJKLMNOPQRSTU";
        for (int i = 0; i < 33; i++) stream[5 + i] = {1'b1, txt[i]};
        for (int i = 0; i < 38; i++) send(stream[i].data, stream[i].rs, 1'b0, 1'b0);

        repeat (5) @(negedge iCLK);
        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
